row_sync_arbiter: RTL and testbench
===================================

Name: row_sync_arbiter

Overview:
- Shares one backing-memory transfer port among the per-bank row caches: BANKGROUPS*BANKSPERGROUP requesters.
- Each bank's cache raises a request to fill or write back one cached row.
- The arbiter grants one bank at a time in round-robin order and sequences a multi-beat row transfer over a valid/ready port.
- On completion it pulses that bank's sync input. It sits between the cache bank array and the memory-side model.

Parameters:
- BGWIDTH, 2, bank-group address width; BANKGROUPS = 2**BGWIDTH
- BAWIDTH, 2, bank address width; BANKSPERGROUP = 2**BAWIDTH
- CHWIDTH, 5, cache row index width
- ADDRWIDTH, 17, DRAM row address width
- BEATWIDTH, 3, beats per row transfer = 2**BEATWIDTH
- Local: NBANKS = BANKGROUPS*BANKSPERGROUP; IDXW = BGWIDTH+BAWIDTH; flat index = bg*BANKSPERGROUP+ba

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- req  in  1 [BANKGROUPS][BANKSPERGROUP]  per-bank transfer request; level
- req_wr  in  1 [BG][BA]  1=writeback cache->mem, 0=fill mem->cache
- req_row  in  ADDRWIDTH [BG][BA]  DRAM row to transfer
- req_crow  in  CHWIDTH [BG][BA]  cache row slot
- sync  out  1 [BG][BA]  one-cycle completion pulse to the granted bank
- gnt_idx  out  IDXW  flat index of the current grant
- busy  out  1  transfer in progress (state != IDLE)
- mem_valid  out  1  beat request valid
- mem_ready  in  1  memory accepts beat
- mem_wr  out  1  latched req_wr
- mem_bank  out  IDXW  latched grant index
- mem_row  out  ADDRWIDTH  latched req_row
- mem_crow  out  CHWIDTH  latched req_crow
- mem_beat  out  BEATWIDTH  current beat number

Behaviour:
- Reset (async, reset_n=0): state=IDLE; sync all 0; mem_valid=0, busy=0; rr pointer=0; beat=0; gnt_idx, mem_* fields=0; mask_valid=0.
- Reset asserted mid-transfer abandons it: no sync pulse, and no beat is issued after reset.
- State IDLE:
  - Candidates = req, excluding the masked index (see DONE).
  - If any candidate exists, pick the first set index searching ptr, ptr+1, ... NBANKS-1, 0, ... (wrap).
  - Register gnt_idx, mem_wr, mem_row, mem_crow from that bank; beat=0; go to XFER.
  - Grant latency is 1 cycle: req sampled at cycle t gives mem_valid=1 at t+1.
  - No candidate: stay in IDLE.
- State XFER:
  - mem_valid=1 and mem_beat=beat; all mem_* fields stay stable until handshake.
  - On mem_valid&&mem_ready: if beat==2**BEATWIDTH-1, go to DONE (mem_valid=0 next cycle); else beat+1.
  - mem_ready low: hold, with no timeout.
  - Changes on req, req_row, req_crow or req_wr during XFER are ignored; operands are latched.
  - req of the granted bank dropping mid-transfer is also ignored and the transfer completes.
- State DONE (one cycle):
  - sync[granted bank]=1; all other sync=0.
  - ptr = (gnt_idx+1) mod NBANKS, with natural IDXW wrap since NBANKS is a power of two.
  - Set mask_valid=1 with mask=gnt_idx; go to IDLE.
- Mask: the index in the mask is excluded from candidates for exactly the first IDLE cycle after DONE, then mask_valid clears.
  - This gives the requester one cycle to drop req after seeing sync.
  - A req still high after that is a new request.
- Simultaneous requests: served strictly round-robin; each of NBANKS persistent requesters is granted at least once per NBANKS transfers.
- busy=1 in XFER and DONE.
- gnt_idx holds its last value while IDLE.
- Minimum cost per transfer: 2**BEATWIDTH+2 cycles. Back-to-back to a different bank: IDLE→XFER with no extra gap.

Decomposition:
- Package row_sync_pkg holds:
  - typedef enum logic [1:0] {IDLE, XFER, DONE} sync_state_t;
  - width-function helpers (NBANKS, IDXW).
- One sub-module, rr_pick: combinational round-robin priority select.
  - Inputs: NBANKS-bit request vector and pointer.
  - Outputs: found flag and IDXW-bit index.
  - Instantiated once. The top level flattens the 2-D req/sync arrays with generate loops.

Test Plan:
- Single request: bank bg=1,ba=2 (idx 6), req_wr=1, row 0x1ABCD, crow 7, mem_ready=1 → mem_valid high 8 cycles starting 1 cycle after req; beats 0..7 in order; mem_bank=6, mem_row=0x1ABCD, mem_crow=7; sync[1][2] pulses once; busy falls in the cycle after DONE.
- Fairness: all 16 banks request at once, ptr=0 → grant order 0,1,...,15. Then bank 3 keeps requesting after its sync → it is not re-granted in the masked cycle and is served again only after the pointer wraps past it.
- Backpressure: mem_ready toggles 1,0,0,1,... → beat advances only on handshakes; mem_row and mem_beat stable while stalled; exactly 8 handshakes before sync.
- Request drop: bank 0 deasserts req at beat 3 → transfer still completes all 8 beats and sync[0][0] still pulses.
- Reset mid-transfer: reset_n low at beat 4 → mem_valid, busy and sync go to 0 immediately (async); after release ptr=0, and with bank 5 requesting, the next grant is bank 5 starting at beat 0.
- Wrap: after bank 15 is served, ptr=0; banks 0 and 14 both request → bank 0 is granted first.

Source files
------------

// File: rtl/row_sync_arbiter_pkg.sv
// Shared types and sizing helpers for the row-cache transfer arbiter.
package row_sync_pkg;

  typedef enum logic [1:0] {IDLE, XFER, DONE} sync_state_t;

  function automatic int nbanks_f(input int bgw, input int baw);
    return 1 << (bgw + baw);
  endfunction

  function automatic int idxw_f(input int bgw, input int baw);
    return bgw + baw;
  endfunction

endpackage

// File: rtl/row_sync_arbiter_if.sv
// Memory-side beat port: arbiter drives a latched row request, memory answers with ready.
interface row_sync_arbiter_if #(
  parameter int IDXW      = 4,
  parameter int ADDRWIDTH = 17,
  parameter int CHWIDTH   = 5,
  parameter int BEATWIDTH = 3
);
  logic                 mem_valid;
  logic                 mem_ready;
  logic                 mem_wr;
  logic [IDXW-1:0]      mem_bank;
  logic [ADDRWIDTH-1:0] mem_row;
  logic [CHWIDTH-1:0]   mem_crow;
  logic [BEATWIDTH-1:0] mem_beat;

  modport master (output mem_valid, mem_wr, mem_bank, mem_row, mem_crow, mem_beat,
                  input  mem_ready);
  modport slave  (input  mem_valid, mem_wr, mem_bank, mem_row, mem_crow, mem_beat,
                  output mem_ready);
endinterface

// File: rtl/row_sync_arbiter_rr_pick.sv
// Round-robin priority select: first set request at or after ptr, wrapping modulo NBANKS.
module rr_pick #(
  parameter int NBANKS = 16,
  parameter int IDXW   = 4
) (
  input  logic [NBANKS-1:0] req,
  input  logic [IDXW-1:0]   ptr,
  output logic              found,
  output logic [IDXW-1:0]   idx
);

  logic [IDXW-1:0] cand;

  // NBANKS is a power of two, so IDXW-bit addition gives the wrap for free.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < NBANKS; i++) begin
      cand = ptr + IDXW'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/row_sync_arbiter.sv
// Grants one bank's row cache at a time onto the shared memory port and
// sequences a 2**BEATWIDTH beat transfer, pulsing that bank's sync on completion.
module row_sync_arbiter
  import row_sync_pkg::*;
#(
  parameter  int BGWIDTH       = 2,
  parameter  int BAWIDTH       = 2,
  parameter  int CHWIDTH       = 5,
  parameter  int ADDRWIDTH     = 17,
  parameter  int BEATWIDTH     = 3,
  localparam int BANKGROUPS    = 1 << BGWIDTH,
  localparam int BANKSPERGROUP = 1 << BAWIDTH,
  localparam int NBANKS        = nbanks_f(BGWIDTH, BAWIDTH),
  localparam int IDXW          = idxw_f(BGWIDTH, BAWIDTH)
) (
  input  logic                                                   clk,
  input  logic                                                   reset_n,
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                req,
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                req_wr,
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][ADDRWIDTH-1:0] req_row,
  input  logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0][CHWIDTH-1:0]   req_crow,
  output logic [BANKGROUPS-1:0][BANKSPERGROUP-1:0]                sync,
  output logic [IDXW-1:0]                                         gnt_idx,
  output logic                                                    busy,
  row_sync_arbiter_if.master                                      mem
);

  logic [NBANKS-1:0]                req_f, wr_f, sync_f;
  logic [NBANKS-1:0][ADDRWIDTH-1:0] row_f;
  logic [NBANKS-1:0][CHWIDTH-1:0]   crow_f;

  for (genvar g = 0; g < BANKGROUPS; g++) begin : g_bg
    for (genvar a = 0; a < BANKSPERGROUP; a++) begin : g_ba
      localparam int F = g * BANKSPERGROUP + a;
      assign req_f[F]   = req[g][a];
      assign wr_f[F]    = req_wr[g][a];
      assign row_f[F]   = req_row[g][a];
      assign crow_f[F]  = req_crow[g][a];
      assign sync[g][a] = sync_f[F];
    end
  end

  sync_state_t          state_q, state_d;
  logic [IDXW-1:0]      ptr_q, ptr_d;
  logic [IDXW-1:0]      gnt_q, gnt_d;
  logic [IDXW-1:0]      mask_q, mask_d;
  logic                 mask_valid_q, mask_valid_d;
  logic [BEATWIDTH-1:0] beat_q, beat_d;
  logic                 wr_q, wr_d;
  logic [ADDRWIDTH-1:0] row_q, row_d;
  logic [CHWIDTH-1:0]   crow_q, crow_d;

  logic [NBANKS-1:0] mask_vec, cand;
  logic              pick_found;
  logic [IDXW-1:0]   pick_idx;

  // The just-served bank is hidden for one IDLE cycle so it can drop req after sync.
  assign mask_vec = mask_valid_q ? (NBANKS'(1) << mask_q) : '0;
  assign cand     = req_f & ~mask_vec;

  rr_pick #(.NBANKS(NBANKS), .IDXW(IDXW)) u_pick (
    .req   (cand),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    mask_d       = mask_q;
    mask_valid_d = mask_valid_q;
    beat_d       = beat_q;
    wr_d         = wr_q;
    row_d        = row_q;
    crow_d       = crow_q;
    case (state_q)
      IDLE: begin
        mask_valid_d = 1'b0;
        if (pick_found) begin
          state_d = XFER;
          gnt_d   = pick_idx;
          wr_d    = wr_f[pick_idx];
          row_d   = row_f[pick_idx];
          crow_d  = crow_f[pick_idx];
          beat_d  = '0;
        end
      end
      XFER: begin
        if (mem.mem_ready) begin
          if (beat_q == '1) state_d = DONE;
          else              beat_d  = beat_q + 1'b1;
        end
      end
      DONE: begin
        ptr_d        = gnt_q + 1'b1;
        mask_d       = gnt_q;
        mask_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      mask_q       <= '0;
      mask_valid_q <= 1'b0;
      beat_q       <= '0;
      wr_q         <= 1'b0;
      row_q        <= '0;
      crow_q       <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      mask_q       <= mask_d;
      mask_valid_q <= mask_valid_d;
      beat_q       <= beat_d;
      wr_q         <= wr_d;
      row_q        <= row_d;
      crow_q       <= crow_d;
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  assign sync_f        = (state_q == DONE) ? (NBANKS'(1) << gnt_q) : '0;
  assign busy          = (state_q != IDLE);
  assign gnt_idx       = gnt_q;
  assign mem.mem_valid = (state_q == XFER);
  assign mem.mem_wr    = wr_q;
  assign mem.mem_bank  = gnt_q;
  assign mem.mem_row   = row_q;
  assign mem.mem_crow  = crow_q;
  assign mem.mem_beat  = beat_q;

endmodule

// File: tb/tb_row_sync_arbiter.sv
// Directed scoreboard bench for row_sync_arbiter: stimulus queues expected beats/syncs, a monitor checks them.
module tb_row_sync_arbiter;
  localparam int BG = 4, BA = 4, NB = 16, IW = 4, AW = 17, CW = 5, BW = 3, NBEAT = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [BG-1:0][BA-1:0]         req, req_wr, sync;
  logic [BG-1:0][BA-1:0][AW-1:0] req_row;
  logic [BG-1:0][BA-1:0][CW-1:0] req_crow;
  logic [IW-1:0]                 gnt_idx;
  logic                          busy;
  logic                          ready_tb;

  row_sync_arbiter_if #(.IDXW(IW), .ADDRWIDTH(AW), .CHWIDTH(CW), .BEATWIDTH(BW)) mif ();
  assign mif.mem_ready = ready_tb;

  row_sync_arbiter #(.BGWIDTH(2), .BAWIDTH(2), .CHWIDTH(CW), .ADDRWIDTH(AW), .BEATWIDTH(BW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_wr   (req_wr),
    .req_row  (req_row),
    .req_crow (req_crow),
    .sync     (sync),
    .gnt_idx  (gnt_idx),
    .busy     (busy),
    .mem      (mif.master)
  );

  typedef struct {
    int           bank;
    logic         wr;
    logic [AW-1:0] row;
    logic [CW-1:0] crow;
    int           beat;
  } beat_t;

  beat_t exp_q[$];
  int    sync_q[$];
  int    keep_n[NB];
  int    checks = 0;
  int    errors = 0;
  int    hs_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_bank(input int b, input logic wr, input logic [AW-1:0] row, input logic [CW-1:0] crow);
    req_wr[b/BA][b%BA]   = wr;
    req_row[b/BA][b%BA]  = row;
    req_crow[b/BA][b%BA] = crow;
  endtask

  task automatic push_xfer(input int b, input int n, input bit with_sync);
    beat_t e;
    for (int k = 0; k < n; k++) begin
      e.bank = b;
      e.wr   = req_wr[b/BA][b%BA];
      e.row  = req_row[b/BA][b%BA];
      e.crow = req_crow[b/BA][b%BA];
      e.beat = k;
      exp_q.push_back(e);
    end
    if (with_sync) sync_q.push_back(b);
  endtask

  task automatic wait_drain(input string nm, input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || sync_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || sync_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: %0d beats %0d syncs outstanding, required 0", nm, exp_q.size(), sync_q.size());
      exp_q.delete();
      sync_q.delete();
    end
  endtask

  task automatic wait_sync(input string nm, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (sync == '0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sync == '0) begin
      checks++;
      errors++;
      $display("FAIL %s: no sync within %0d cycles, required a pulse", nm, bound);
    end
  endtask

  task automatic wait_beat(input string nm, input int bt, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!(mif.mem_valid && mif.mem_beat == BW'(bt)) && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!(mif.mem_valid && mif.mem_beat == BW'(bt))) begin
      checks++;
      errors++;
      $display("FAIL %s: beat %0d never presented, got beat %0h", nm, bt, mif.mem_beat);
    end
  endtask

  // Monitor: checks every presented beat against the queue head; pops on handshake.
  initial begin
    beat_t e;
    int    s;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mif.mem_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got bank %0d beat %0d, required none", mif.mem_bank, mif.mem_beat);
          end else begin
            e = exp_q[0];
            chk("mem_bank", 64'(mif.mem_bank), 64'(e.bank));
            chk("gnt_idx",  64'(gnt_idx),      64'(e.bank));
            chk("mem_wr",   64'(mif.mem_wr),   64'(e.wr));
            chk("mem_row",  64'(mif.mem_row),  64'(e.row));
            chk("mem_crow", 64'(mif.mem_crow), 64'(e.crow));
            chk("mem_beat", 64'(mif.mem_beat), 64'(e.beat));
            if (ready_tb) begin
              void'(exp_q.pop_front());
              hs_cnt++;
            end
          end
        end
        if (sync != '0) begin
          if (sync_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_sync: got %04h, required none", sync);
          end else begin
            s = sync_q.pop_front();
            chk("sync", 64'(sync), 64'(16'(1) << s));
          end
          // Requester side: a bank drops req on seeing its sync unless told to persist.
          for (int b = 0; b < NB; b++) begin
            if (sync[b/BA][b%BA]) begin
              if (keep_n[b] > 0) keep_n[b]--;
              else req[b/BA][b%BA] = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin
    int hs0;
    req = '0; req_wr = '0; req_row = '0; req_crow = '0; ready_tb = 1'b1;
    for (int b = 0; b < NB; b++) begin
      keep_n[b] = 0;
      set_bank(b, b[0], AW'(17'h10000 + b * 17'h123), CW'(b + 3));
    end

    // Reset state
    @(negedge clk);
    chk("rst_busy",  64'(busy), 0);
    chk("rst_valid", 64'(mif.mem_valid), 0);
    chk("rst_sync",  64'(sync), 0);
    chk("rst_gnt",   64'(gnt_idx), 0);
    chk("rst_row",   64'(mif.mem_row), 0);
    chk("rst_beat",  64'(mif.mem_beat), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Single request, bank 6, with one-cycle grant latency
    @(posedge clk); #1;
    set_bank(6, 1'b1, 17'h1ABCD, 5'd7);
    push_xfer(6, NBEAT, 1);
    req[1][2] = 1'b1;
    @(negedge clk); chk("lat_pre_valid", 64'(mif.mem_valid), 0);
    @(negedge clk); chk("lat_valid", 64'(mif.mem_valid), 1);
    wait_sync("single_sync", 40);
    chk("busy_in_done", 64'(busy), 1);
    @(negedge clk); chk("busy_after_done", 64'(busy), 0);
    wait_drain("single", 40);

    // Reset mid-transfer (ptr is 7 here); afterwards ptr=0 so bank 5 beats bank 12
    @(posedge clk); #1;
    push_xfer(9, 5, 0);
    req[2][1] = 1'b1;
    wait_beat("abort_beat4", 4, 40);
    #1 reset_n = 1'b0; req[2][1] = 1'b0;
    #1;
    chk("abort_valid", 64'(mif.mem_valid), 0);
    chk("abort_busy",  64'(busy), 0);
    chk("abort_sync",  64'(sync), 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    push_xfer(5, NBEAT, 1);
    push_xfer(12, NBEAT, 1);
    req[1][1] = 1'b1; req[3][0] = 1'b1;
    wait_drain("post_reset", 80);

    // Backpressure on bank 2, ready pattern 1,0,0 repeating
    @(posedge clk); #1;
    hs0 = hs_cnt;
    push_xfer(2, NBEAT, 1);
    req[0][2] = 1'b1;
    for (int c = 0; c < 200 && (exp_q.size() != 0 || sync_q.size() != 0); c++) begin
      ready_tb = (c % 3 == 0);
      @(posedge clk); #1;
    end
    ready_tb = 1'b1;
    wait_drain("backpressure", 20);
    chk("bp_handshakes", 64'(hs_cnt - hs0), 64'(NBEAT));

    // Request drop at beat 3 on bank 0; operands changed mid-transfer are ignored
    @(posedge clk); #1;
    push_xfer(0, NBEAT, 1);
    req[0][0] = 1'b1;
    wait_beat("drop_beat3", 3, 40);
    #1 req[0][0] = 1'b0;
    req_row[0][0] = 17'h0DEAD; req_crow[0][0] = 5'd30; req_wr[0][0] = ~req_wr[0][0];
    wait_drain("drop", 40);
    set_bank(0, 1'b0, 17'h10000, 5'd3);

    // Bank 15 persists past its sync: skipped in the masked cycle, regranted one cycle later
    @(posedge clk); #1;
    keep_n[15] = 1;
    push_xfer(15, NBEAT, 1);
    push_xfer(15, NBEAT, 1);
    req[3][3] = 1'b1;
    wait_sync("mask_sync", 40);
    @(negedge clk);
    @(negedge clk); chk("mask_idle2_valid", 64'(mif.mem_valid), 0);
    @(negedge clk); chk("mask_regrant_valid", 64'(mif.mem_valid), 1);
    wait_drain("mask", 40);

    // Fairness from ptr=0: 0..15, then persistent bank 3 again after the wrap
    @(posedge clk); #1;
    keep_n[3] = 1;
    for (int b = 0; b < NB; b++) push_xfer(b, NBEAT, 1);
    push_xfer(3, NBEAT, 1);
    req = '1;
    wait_drain("fairness", 400);

    // Wrap: serve 15 so ptr returns to 0, then 0 and 14 together -> 0 first
    @(posedge clk); #1;
    push_xfer(15, NBEAT, 1);
    req[3][3] = 1'b1;
    wait_drain("wrap_15", 40);
    @(posedge clk); #1;
    push_xfer(0, NBEAT, 1);
    push_xfer(14, NBEAT, 1);
    req[0][0] = 1'b1; req[3][2] = 1'b1;
    wait_drain("wrap", 60);
    repeat (3) @(negedge clk);
    chk("final_busy", 64'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
